conv3x3_filter: RTL

- Downstream consumer of the 3x3 window generator.
- Accepts one packed 3x3 RGB888 window per handshake and applies a run-time-selected integer kernel to each colour channel independently.
- Clamps each result to 8 bits and writes one output pixel per window into the output frame BRAM in raster order.
- Pulses frame_done after the last pixel of the frame is written.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv3x3_filter_if.sv | 34 +++
 rtl/conv3x3_channel.sv | 114 +++++++++++
 rtl/conv3x3_filter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM encoding and saturation helper for the 3x3 convolution block.
package conv_pkg;

    // Kernel select codes; 5..7 fall back to identity.
    localparam logic [2:0] KSEL_IDENT = 3'd0;
    localparam logic [2:0] KSEL_BOX   = 3'd1;
    localparam logic [2:0] KSEL_GAUSS = 3'd2;
    localparam logic [2:0] KSEL_SHARP = 3'd3;
    localparam logic [2:0] KSEL_LAPL  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Box blur: sum9 * 455 >> 12 approximates sum9 / 9.
    localparam int unsigned BOX_MUL   = 455;
    localparam int unsigned BOX_SHIFT = 12;

    // Luma weights, sum to 256.
    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

    // Clamp a signed 14-bit intermediate into [0,255].
    function automatic logic [7:0] sat_u8(input logic signed [13:0] v);
        if (v < 14'sd0) begin
            return 8'd0;
        end else if (v > 14'sd255) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/conv3x3_filter_if.sv
// conv3x3_filter_if: window stream in (valid/ready/data) and output frame BRAM write bus.
interface conv3x3_filter_if #(
    parameter int unsigned PIX_W  = 24,
    parameter int unsigned ADDR_W = 17
) ();

    logic                 i_valid;
    logic                 i_ready;
    logic [PIX_W*9-1:0]   i_data;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [PIX_W-1:0]     wr_data;

    // Upstream window source and BRAM observer side.
    modport master (
        output i_valid,
        output i_data,
        input  i_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    // Filter side.
    modport slave (
        input  i_valid,
        input  i_data,
        output i_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/conv3x3_channel.sv
// conv3x3_channel: three-stage kernel datapath for one 8-bit colour channel.
// S1 weighted terms (shifts/adds), S2 signed adder tree, S3 normalise + clamp.
module conv3x3_channel
    import conv_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [2:0]  i_kernel_sel,   // frame-constant, so one copy serves all stages
    input  logic [71:0] i_win,          // {p22..p00}, p00 in LSBs
    output logic [7:0]  o_pix
);

    logic signed [13:0] w_p    [9];
    logic signed [13:0] w_term [9];
    logic signed [13:0] r_s1   [9];
    logic signed [13:0] w_sum;
    logic signed [13:0] r_s2;
    logic        [20:0] w_box_prod;
    logic signed [13:0] w_abs;
    logic signed [13:0] w_norm;
    logic        [7:0]  r_s3;

    // S1: select per-tap weights; corners 0,2,6,8, edges 1,3,5,7, centre 4.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_p[i]    = $signed({6'b0, i_win[8*i +: 8]});
            w_term[i] = '0;
        end
        case (i_kernel_sel)
            KSEL_BOX: begin
                for (int i = 0; i < 9; i++) begin
                    w_term[i] = w_p[i];
                end
            end
            KSEL_GAUSS: begin
                for (int i = 0; i < 9; i += 2) begin
                    w_term[i] = w_p[i];
                end
                for (int i = 1; i < 9; i += 2) begin
                    w_term[i] = w_p[i] <<< 1;
                end
                w_term[4] = w_p[4] <<< 2;
            end
            KSEL_SHARP: begin
                for (int i = 1; i < 9; i += 2) begin
                    w_term[i] = -w_p[i];
                end
                w_term[4] = (w_p[4] <<< 2) + w_p[4];
            end
            KSEL_LAPL: begin
                for (int i = 1; i < 9; i += 2) begin
                    w_term[i] = w_p[i];
                end
                w_term[4] = -(w_p[4] <<< 2);
            end
            default: begin
                w_term[4] = w_p[4];
            end
        endcase
    end

    // S1 register.
    always_ff @(posedge iClk) begin
        for (int i = 0; i < 9; i++) begin
            if (!iRst_n) begin
                r_s1[i] <= '0;
            end else begin
                r_s1[i] <= w_term[i];
            end
        end
    end

    // S2: adder tree over the nine terms.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) begin
            w_sum = w_sum + r_s1[i];
        end
    end

    // S2 register.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_s2 <= '0;
        end else begin
            r_s2 <= w_sum;
        end
    end

    // S3: kernel-specific normalisation; box sum9 is never negative and fits 12 bits.
    always_comb begin
        w_box_prod = 21'(r_s2[11:0]) * 21'(BOX_MUL);
        w_abs      = r_s2[13] ? -r_s2 : r_s2;
        case (i_kernel_sel)
            KSEL_BOX:   w_norm = $signed(14'(w_box_prod >> BOX_SHIFT));
            KSEL_GAUSS: w_norm = r_s2 >>> 4;
            KSEL_SHARP: w_norm = r_s2;
            KSEL_LAPL:  w_norm = w_abs;
            default:    w_norm = r_s2;
        endcase
    end

    // S3 register: clamped channel result.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_s3 <= '0;
        end else begin
            r_s3 <= sat_u8(w_norm);
        end
    end

    assign o_pix = r_s3;

endmodule

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: applies a run-time selected 3x3 kernel to RGB888 windows and writes
// one pixel per window to the output BRAM in raster order.
// Optional macro CONV_GRAY_OUT_EN: adds a luma stage, output {Y,Y,Y}, latency 4.
module conv3x3_filter
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 480,
    parameter int unsigned IMG_H  = 272,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 24
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              i_start,
    input  logic [2:0]        i_kernel_sel,
    conv3x3_filter_if.slave   bus,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned       NPIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
`ifdef CONV_GRAY_OUT_EN
    localparam int unsigned       LAT      = 4;
`else
    localparam int unsigned       LAT      = 3;
`endif

    state_e              r_state;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic [2:0]          r_ksel;
    logic [ADDR_W-1:0]   r_acc_cnt;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [LAT-1:0]      r_vld;
    logic                w_accept;
    logic                w_last_wr;
    logic [71:0]         w_win_r;
    logic [71:0]         w_win_g;
    logic [71:0]         w_win_b;
    logic [7:0]          w_r;
    logic [7:0]          w_g;
    logic [7:0]          w_b;

    assign w_accept  = bus.i_valid && r_ready;
    assign w_last_wr = r_vld[LAT-1] && (r_wr_addr == LAST_IDX);

    // Split the packed RGB window into three per-channel windows.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_win_r[8*k +: 8] = bus.i_data[PIX_W*k + 16 +: 8];
            w_win_g[8*k +: 8] = bus.i_data[PIX_W*k + 8  +: 8];
            w_win_b[8*k +: 8] = bus.i_data[PIX_W*k      +: 8];
        end
    end

    conv3x3_channel u_ch_r (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .i_kernel_sel (r_ksel),
        .i_win        (w_win_r),
        .o_pix        (w_r)
    );

    conv3x3_channel u_ch_g (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .i_kernel_sel (r_ksel),
        .i_win        (w_win_g),
        .o_pix        (w_g)
    );

    conv3x3_channel u_ch_b (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .i_kernel_sel (r_ksel),
        .i_win        (w_win_b),
        .o_pix        (w_b)
    );

    // Frame FSM with registered handshake/status outputs.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ksel    <= KSEL_IDENT;
            r_acc_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ksel    <= i_kernel_sel;
                        r_acc_cnt <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_acc_cnt == LAST_IDX) begin
                            r_acc_cnt <= '0;
                            r_ready   <= 1'b0;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_acc_cnt <= r_acc_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last write marks an empty pipeline regardless of its depth.
                    if (w_last_wr) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Valid shift register tracking windows through the datapath.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LAT-2:0], w_accept};
        end
    end

    // Raster write address; wraps to 0 after the last pixel so it never overruns.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_wr_addr <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_wr_addr <= '0;
        end else if (r_vld[LAT-1]) begin
            r_wr_addr <= (r_wr_addr == LAST_IDX) ? '0 : r_wr_addr + 1'b1;
        end
    end

`ifdef CONV_GRAY_OUT_EN
    logic [15:0] w_y_sum;
    logic [7:0]  r_y;

    always_comb begin
        w_y_sum = 16'(LUMA_R) * 16'(w_r) + 16'(LUMA_G) * 16'(w_g) + 16'(LUMA_B) * 16'(w_b);
    end

    // Luma stage.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_y <= '0;
        end else begin
            r_y <= 8'(w_y_sum >> 8);
        end
    end

    assign bus.wr_data = {r_y, r_y, r_y};
`else
    assign bus.wr_data = {w_r, w_g, w_b};
`endif

    assign bus.i_ready = r_ready;
    assign bus.wr_en   = r_vld[LAT-1];
    assign bus.wr_addr = r_wr_addr;
    assign frame_done  = r_done;
    assign busy        = r_busy;

endmodule
